instr_fetch_unit: RTL

// - Front-end fetch stage feeding instruction identify and the branch unit.
// - Holds the fetch PC, issues one-word requests to the instruction memory via a

---
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: holds the fetch PC, keeps one instruction-memory request outstanding at a time,
// and buffers returned words with their addresses in an in-order FIFO that a redirect flushes.
module instr_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [0:63] RESET_PC = 64'h0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_32b_mode,
    input  logic                  i_redirect,
    input  logic [0:63]           i_redirect_addr,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic [0:63]           o_mem_req_addr,
    input  logic                  i_mem_resp_valid,
    input  logic [0:31]           i_mem_resp_data,
    input  logic                  i_mem_resp_err,
    output logic                  o_instr_valid,
    output logic [0:31]           o_instr,
    output logic [0:63]           o_instr_addr,
    input  logic                  i_instr_ready,
    output logic                  o_fetch_fault,
    output logic [$clog2(DEPTH):0] o_buf_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FAULT} state_t;

    state_t        r_state;
    logic          r_drop;
    logic [0:63]   r_fpc;
    logic [0:63]   r_req_addr;
    logic [0:31]   r_data [DEPTH];
    logic [0:63]   r_addr [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;

    logic          w_pop;
    logic          w_push;
    logic          w_accept;
    logic [0:63]   w_redir_pc;
    logic [0:63]   w_next_pc;

    function automatic logic [0:63] fit_mode(input logic [0:63] a, input logic m);
        return m ? {32'h0, a[32:63]} : a;
    endfunction

    assign w_accept   = (r_state == REQ) && i_mem_req_ready;
    assign w_pop      = (r_count != '0) && i_instr_ready && !i_redirect;
    assign w_push     = (r_state == WAIT) && i_mem_resp_valid && !i_mem_resp_err && !r_drop && !i_redirect;
    assign w_redir_pc = fit_mode({i_redirect_addr[0:61], 2'b00}, i_32b_mode);
    assign w_next_pc  = fit_mode(r_fpc + 64'd4, i_32b_mode);

    assign o_mem_req_valid = (r_state == REQ);
    assign o_fetch_fault   = (r_state == FAULT);
    assign o_mem_req_addr  = r_req_addr;
    assign o_instr_valid   = (r_count != '0);
    assign o_instr         = o_instr_valid ? r_data[r_rp] : '0;
    assign o_instr_addr    = o_instr_valid ? r_addr[r_rp] : '0;
    assign o_buf_count     = r_count;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_data[r_wp] <= i_mem_resp_data;
            r_addr[r_wp] <= r_req_addr;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_drop     <= 1'b0;
            r_fpc      <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
        end else begin
            if (i_redirect) begin
                r_wp    <= '0;
                r_rp    <= '0;
                r_count <= '0;
            end else begin
                if (w_push)
                    r_wp <= r_wp + AW'(1);
                if (w_pop)
                    r_rp <= r_rp + AW'(1);
                r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            end
            // a dropped (pre-redirect) request must not advance the new fetch PC
            if (i_redirect)
                r_fpc <= w_redir_pc;
            else if (w_accept && !r_drop)
                r_fpc <= w_next_pc;
            case (r_state)
                IDLE: begin
                    if (!i_redirect && r_count < FULL) begin
                        r_state    <= REQ;
                        r_req_addr <= r_fpc;
                    end
                end
                REQ: begin
                    if (i_redirect)
                        r_drop <= 1'b1;
                    if (w_accept)
                        r_state <= WAIT;
                end
                WAIT: begin
                    // a response arriving with the redirect is already discarded, so no drop is armed
                    if (i_mem_resp_valid) begin
                        r_drop  <= 1'b0;
                        r_state <= (i_mem_resp_err && !r_drop && !i_redirect) ? FAULT : IDLE;
                    end else if (i_redirect) begin
                        r_drop <= 1'b1;
                    end
                end
                FAULT: begin
                    if (i_redirect)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
